// File: rtl/calc_pkg.sv
// Shared types and helpers for the accumulating calculator core.
//   func_e        : 3-bit opcode encoding driven on the func input.
//   state_e       : controller states (S_DIV only reachable with CALC_SEQ_DIV_EN).
//   calc_res_t_ok : width-check helper; the accumulator must hold a full W x W product.
package calc_pkg;

  typedef enum logic [2:0] {
    FN_ADD = 3'b000,
    FN_SUB = 3'b001,
    FN_MUL = 3'b010,
    FN_DIV = 3'b011,
    FN_MOD = 3'b100,
    FN_SQR = 3'b101,
    FN_CLR = 3'b110,
    FN_NOP = 3'b111
  } func_e;

  typedef enum logic [1:0] {
    S_INIT = 2'd0,  // no accumulator: operand A comes from num1
    S_ACC  = 2'd1,  // chaining: operand A is the current result
    S_DIV  = 2'd2   // iterative divider running
  } state_e;

  // Accumulator width rule: RW >= 2*W.
  function automatic bit calc_res_t_ok(input int unsigned w, input int unsigned rw);
    return rw >= 2 * w;
  endfunction

endpackage

// File: rtl/calc_seq_div.sv
// RW-bit restoring divider, one quotient bit per clock.
// The first iteration is taken on the start edge straight from the inputs,
// so the last of the RW iterations lands on edge RW-1 and done is high in
// the cycle that follows; the caller commits the answer on edge RW.
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset (aborts a run)
//   start              : load operands and begin (divisor must be nonzero)
//   dividend, divisor  : operands, sampled only on the start edge
//   quotient, remainder: results, valid while done is high
//   done               : high for one cycle when the result is ready
module calc_seq_div #(
  parameter int unsigned RW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [RW-1:0] dividend,
  input  logic [RW-1:0] divisor,
  output logic [RW-1:0] quotient,
  output logic [RW-1:0] remainder,
  output logic          done
);

  localparam int unsigned CW = $clog2(RW + 1);

  logic [RW-1:0] rem_q, quo_q, div_q;
  logic [CW-1:0] cnt_q;
  logic          run_q;

  logic [RW-1:0] src_rem, src_quo, src_div;
  logic [RW:0]   shifted, trial;
  logic [RW-1:0] step_rem, step_quo;

  // One restoring step. The partial remainder stays below the divisor, so
  // shifted < 2*divisor and the trial difference's MSB is a clean borrow.
  always_comb begin
    src_rem  = start ? '0       : rem_q;
    src_quo  = start ? dividend : quo_q;
    src_div  = start ? divisor  : div_q;
    shifted  = {src_rem, src_quo[RW-1]};
    trial    = shifted - {1'b0, src_div};
    step_rem = trial[RW] ? shifted[RW-1:0] : trial[RW-1:0];
    step_quo = {src_quo[RW-2:0], ~trial[RW]};
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q <= '0;
      quo_q <= '0;
      div_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (start) begin
      rem_q <= step_rem;
      quo_q <= step_quo;
      div_q <= divisor;
      cnt_q <= CW'(RW - 1);
      run_q <= 1'b1;
    end else if (run_q) begin
      if (cnt_q != '0) begin
        rem_q <= step_rem;
        quo_q <= step_quo;
        cnt_q <= cnt_q - 1'b1;
      end else begin
        run_q <= 1'b0;
      end
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign done      = run_q && (cnt_q == '0);

endmodule

// File: rtl/calc_acc_core.sv
// Accumulating calculator core. Each button press applies one opcode either
// to (num1, num2) or, once chaining, to (result, num2).
// Build option: define CALC_SEQ_DIV_EN to run div/mod on the RW-cycle
// iterative divider (busy functional); otherwise div/mod are single-cycle.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   button       : debounced press request; rising level = one press
//   func         : opcode (see calc_pkg::func_e)
//   num1, num2   : W-bit operands (num1 only used from S_INIT)
//   result       : RW-bit accumulator
//   valid        : one-cycle pulse after result is written
//   busy         : divider running, presses dropped
//   ovf, err     : wrap/truncation flag, divide-by-zero flag
//   chain        : accumulator holds an operand
module calc_acc_core
  import calc_pkg::*;
#(
  parameter int unsigned W  = 8,
  parameter int unsigned RW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          button,
  input  logic [2:0]    func,
  input  logic [W-1:0]  num1,
  input  logic [W-1:0]  num2,
  output logic [RW-1:0] result,
  output logic          valid,
  output logic          busy,
  output logic          ovf,
  output logic          err,
  output logic          chain
);

  if (!calc_res_t_ok(W, RW)) begin : g_width_check
    $error("calc_acc_core: RW must be at least 2*W");
  end

  state_e        state_q, state_d;
  logic [RW-1:0] result_q, result_d;
  logic          valid_q, valid_d;
  logic          ovf_q, ovf_d;
  logic          err_q, err_d;
  logic          chain_q, chain_d;
  logic          button_d_q;

  logic          press;
  func_e         fn;
  logic [RW-1:0] op_a, op_b, sq_src, mul_a, mul_b;
  logic [RW:0]   sum, diff;
  logic [2*RW-1:0] prod;
  logic          commit;

  // The edge detector runs even while busy, so a button held across the end
  // of a division does not fire when busy falls.
  assign press = button & ~button_d_q;
  assign fn    = func_e'(func);

  assign op_a   = (state_q == S_ACC) ? result_q : RW'(num1);
  assign op_b   = RW'(num2);
  assign sq_src = (state_q == S_ACC) ? result_q : op_b;
  assign mul_a  = (fn == FN_SQR) ? sq_src : op_a;
  assign mul_b  = (fn == FN_SQR) ? sq_src : op_b;
  assign sum    = {1'b0, op_a} + {1'b0, op_b};
  assign diff   = {1'b0, op_a} - {1'b0, op_b};
  assign prod   = {{RW{1'b0}}, mul_a} * {{RW{1'b0}}, mul_b};

`ifdef CALC_SEQ_DIV_EN
  logic          div_start;
  logic [RW-1:0] div_quo, div_rem;
  logic          div_done;
  logic          is_mod_q, is_mod_d;

  calc_seq_div #(.RW(RW)) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (div_start),
    .dividend  (op_a),
    .divisor   (op_b),
    .quotient  (div_quo),
    .remainder (div_rem),
    .done      (div_done)
  );

  assign busy = (state_q == S_DIV);
`else
  logic [RW-1:0] quo, rem;

  // Only consumed when op_b is nonzero.
  assign quo  = op_a / op_b;
  assign rem  = op_a % op_b;
  assign busy = 1'b0;
`endif

  // NOTE: every combinational output gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    err_d    = err_q;
    chain_d  = chain_q;
    valid_d  = 1'b0;
    commit   = 1'b0;
`ifdef CALC_SEQ_DIV_EN
    div_start = 1'b0;
    is_mod_d  = is_mod_q;

    if (state_q == S_DIV) begin
      if (div_done) begin
        result_d = is_mod_q ? div_rem : div_quo;
        ovf_d    = 1'b0;
        commit   = 1'b1;
      end
    end else
`endif
    if (press) begin
      unique case (fn)
        FN_ADD: begin
          result_d = sum[RW-1:0];
          ovf_d    = sum[RW];
          commit   = 1'b1;
        end
        FN_SUB: begin
          result_d = diff[RW-1:0];
          ovf_d    = diff[RW];
          commit   = 1'b1;
        end
        FN_MUL, FN_SQR: begin
          result_d = prod[RW-1:0];
          ovf_d    = |prod[2*RW-1:RW];
          commit   = 1'b1;
        end
        FN_DIV, FN_MOD: begin
          if (op_b == '0) begin
            err_d = 1'b1;
          end else begin
`ifdef CALC_SEQ_DIV_EN
            div_start = 1'b1;
            is_mod_d  = (fn == FN_MOD);
            state_d   = S_DIV;
`else
            result_d = (fn == FN_MOD) ? rem : quo;
            ovf_d    = 1'b0;
            commit   = 1'b1;
`endif
          end
        end
        FN_CLR: begin
          result_d = '0;
          ovf_d    = 1'b0;
          err_d    = 1'b0;
          chain_d  = 1'b0;
          state_d  = S_INIT;
          valid_d  = 1'b1;
        end
        default: ;  // FN_NOP
      endcase
    end

    if (commit) begin
      valid_d = 1'b1;
      err_d   = 1'b0;
      chain_d = 1'b1;
      state_d = S_ACC;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_INIT;
      result_q   <= '0;
      valid_q    <= 1'b0;
      ovf_q      <= 1'b0;
      err_q      <= 1'b0;
      chain_q    <= 1'b0;
      button_d_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      result_q   <= result_d;
      valid_q    <= valid_d;
      ovf_q      <= ovf_d;
      err_q      <= err_d;
      chain_q    <= chain_d;
      button_d_q <= button;
    end
  end

`ifdef CALC_SEQ_DIV_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) is_mod_q <= 1'b0;
    else        is_mod_q <= is_mod_d;
  end
`endif

  assign result = result_q;
  assign valid  = valid_q;
  assign ovf    = ovf_q;
  assign err    = err_q;
  assign chain  = chain_q;

endmodule

// File: tb/tb_calc_acc_core.sv
// Directed bench for calc_acc_core (W=8, RW=32). Works in both builds; the
// busy/latency checks are only active with CALC_SEQ_DIV_EN.
module tb_calc_acc_core;
  import calc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        button;
  logic [2:0]  func;
  logic [7:0]  num1, num2;
  logic [31:0] result;
  logic        valid, busy, ovf, err, chain;

  int n_vec  = 0;
  int n_fail = 0;

  calc_acc_core #(.W(8), .RW(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .button (button),
    .func   (func),
    .num1   (num1),
    .num2   (num2),
    .result (result),
    .valid  (valid),
    .busy   (busy),
    .ovf    (ovf),
    .err    (err),
    .chain  (chain)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive a press on the next negedge; returns 1 time unit after the press edge
  // with button still held.
  task automatic press(input func_e f, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    func   = f;
    num1   = a;
    num2   = b;
    button = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic release_btn;
    @(negedge clk);
    button = 1'b0;
  endtask

  // Wait out a running division (bounded); no-op in the single-cycle build.
  task automatic finish_op;
`ifdef CALC_SEQ_DIV_EN
    for (int i = 0; i < 40 && busy; i++) begin
      @(negedge clk);
      button = 1'b0;
      @(posedge clk);
      #1;
    end
    if (busy) check("div_timeout", 32'(busy), 32'd0);
`endif
  endtask

  int busy_cnt, valid_cnt;

  initial begin
    rst_n  = 1'b0;
    button = 1'b0;
    func   = FN_NOP;
    num1   = '0;
    num2   = '0;
    #12;
    check("rst_result", result, 32'd0);
    check("rst_valid",  32'(valid), 32'd0);
    check("rst_busy",   32'(busy),  32'd0);
    check("rst_ovf",    32'(ovf),   32'd0);
    check("rst_err",    32'(err),   32'd0);
    check("rst_chain",  32'(chain), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 12 + 5 from S_INIT, then hold the button for 10 cycles.
    press(FN_ADD, 8'd12, 8'd5);
    check("add_result", result, 32'd17);
    check("add_valid",  32'(valid), 32'd1);
    check("add_ovf",    32'(ovf),   32'd0);
    check("add_chain",  32'(chain), 32'd1);
    valid_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (valid) valid_cnt++;
    end
    check("hold_no_valid",  32'(valid_cnt), 32'd0);
    check("hold_result",    result, 32'd17);
    release_btn();

    // Chained: 17*3, then square, square, square (last one truncates).
    press(FN_MUL, 8'd99, 8'd3);
    check("mul_chain", result, 32'd51);
    release_btn();
    press(FN_SQR, 8'd0, 8'd0);
    check("sqr_chain", result, 32'd2601);
    check("sqr_ovf",   32'(ovf), 32'd0);
    release_btn();
    press(FN_SQR, 8'd0, 8'd0);
    check("sqr2", result, 32'd6765201);
    release_btn();
    press(FN_SQR, 8'd0, 8'd0);
    check("sqr3_trunc", result, 32'd773064225);
    check("sqr3_ovf",   32'(ovf), 32'd1);
    release_btn();

    // No-op changes nothing and does not pulse valid.
    press(FN_NOP, 8'd1, 8'd1);
    check("nop_result", result, 32'd773064225);
    check("nop_valid",  32'(valid), 32'd0);
    check("nop_ovf",    32'(ovf), 32'd1);
    release_btn();

    // Clear, then 3 - 5 wraps with borrow; chained +1 clears ovf.
    press(FN_CLR, 8'd0, 8'd0);
    check("clr_result", result, 32'd0);
    check("clr_valid",  32'(valid), 32'd1);
    check("clr_chain",  32'(chain), 32'd0);
    release_btn();
    press(FN_SUB, 8'd3, 8'd5);
    check("sub_result", result, 32'hFFFF_FFFE);
    check("sub_ovf",    32'(ovf), 32'd1);
    release_btn();
    press(FN_ADD, 8'd0, 8'd1);
    check("add_after_sub", result, 32'hFFFF_FFFF);
    check("add_clr_ovf",   32'(ovf), 32'd0);
    release_btn();

    // 200 / 7 from S_INIT.
    press(FN_CLR, 8'd0, 8'd0);
    release_btn();
    press(FN_DIV, 8'd200, 8'd7);
`ifdef CALC_SEQ_DIV_EN
    check("div_busy_rise", 32'(busy), 32'd1);
    check("div_no_valid",  32'(valid), 32'd0);
    busy_cnt  = 1;
    valid_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 0) button = 1'b0;
      if (i == 5) begin  // press while busy with different inputs
        button = 1'b1;
        func   = FN_ADD;
        num2   = 8'd9;
      end
      if (i == 7) button = 1'b0;
      @(posedge clk);
      #1;
      if (busy)  busy_cnt++;
      if (valid) valid_cnt++;
    end
    check("div_busy_cycles", 32'(busy_cnt),  32'd32);
    check("div_valid_cnt",   32'(valid_cnt), 32'd1);
`else
    check("div_valid", 32'(valid), 32'd1);
    release_btn();
`endif
    check("div_result", result, 32'd28);
    check("div_chain",  32'(chain), 32'd1);

    // Chained 28 % 5.
    press(FN_MOD, 8'd77, 8'd5);
    finish_op();
    check("mod_result", result, 32'd3);
    check("mod_valid",  32'(valid), 32'd1);
    release_btn();

    // Divide-by-zero leaves the accumulator alone.
    press(FN_CLR, 8'd0, 8'd0);
    release_btn();
    press(FN_ADD, 8'd28, 8'd0);
    check("load28", result, 32'd28);
    release_btn();
    press(FN_DIV, 8'd0, 8'd0);
    check("dz_result", result, 32'd28);
    check("dz_err",    32'(err),   32'd1);
    check("dz_valid",  32'(valid), 32'd0);
    check("dz_busy",   32'(busy),  32'd0);
    release_btn();
    press(FN_CLR, 8'd0, 8'd0);
    check("clr2_result", result, 32'd0);
    check("clr2_err",    32'(err),   32'd0);
    check("clr2_chain",  32'(chain), 32'd0);
    release_btn();

    // Asynchronous reset in the middle of a division.
    press(FN_ADD, 8'd1, 8'd1);
    release_btn();
    press(FN_DIV, 8'd0, 8'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      button = 1'b0;
      @(posedge clk);
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_result", result, 32'd0);
    check("arst_valid",  32'(valid), 32'd0);
    check("arst_busy",   32'(busy),  32'd0);
    check("arst_ovf",    32'(ovf),   32'd0);
    check("arst_err",    32'(err),   32'd0);
    check("arst_chain",  32'(chain), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    press(FN_ADD, 8'd4, 8'd6);
    check("post_rst_init", result, 32'd10);
    check("post_rst_busy", 32'(busy), 32'd0);
    release_btn();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
